oam_dma: RTL and testbench
==========================

# oam_dma

Sprite DMA engine of the 2A03 core. It sits directly downstream of the $4014 page register and consumes its output. On a write to $4014, it halts the CPU and copies 256 bytes from CPU page `$XX00–$XXFF` to the PPU OAM data port `$2004` using alternating get/put bus cycles. It owns the CPU bus for the whole transfer and hands it back when done.

## Interface
Parameters:
- `P_page_width`, 8: width of the page number.
- `P_oam_port`, 16'h2004: address written on every put cycle.

Ports:
- `I_clock`  in  1  CPU cycle clock.
- `I_reset`  in  1  asynchronous, active-high reset.
- `I_start`  in  1  one-cycle pulse, coincident with a write to $4014.
- `I_page`  in  8  page register output; sampled when `I_start`=1.
- `I_cpu_read`  in  1  the CPU's current cycle is a read (halt may only land on a read).
- `I_data`  in  8  bus read data, valid at the end of a get cycle.
- `O_halt`  out  1  RDY-low request / bus takeover.
- `O_busy`  out  1  a transfer is pending or active.
- `O_addr`  out  16  bus address while the engine owns the bus.
- `O_data`  out  8  bus write data.
- `O_read`  out  1  get-cycle strobe.
- `O_write`  out  1  put-cycle strobe.

## Operation
- **Parity flop:** free-running toggle. 0 = get cycle, 1 = put cycle. Reset value is 0.
- **FSM states:** IDLE, HALT, ALIGN, GET, PUT.
- **IDLE:** `I_start` latches `I_page`, clears the 8-bit byte counter, and moves to HALT. `I_start` in any other state is ignored.
- **HALT:** `O_halt`=1.
  - Stay in HALT while `I_cpu_read`=0.
  - On the cycle with `I_cpu_read`=1 (the halt cycle): go to GET if the next cycle's parity is 0, otherwise go to ALIGN.
- **ALIGN:** one dummy cycle with no strobes, then go to GET.
- **GET:** drive `O_addr`={page, count} and `O_read`=1. Latch `I_data` at the end of the cycle. Go to PUT.
- **PUT:** drive `O_addr`=`P_oam_port`, `O_data`=the latched byte, and `O_write`=1.
  - If count=255: go to IDLE.
  - Otherwise: increment count and go to GET.
- **Output levels:**
  - `O_halt`=1 in HALT, ALIGN, GET and PUT.
  - `O_busy`=`O_halt`.
  - `O_read`/`O_write` are 0 outside GET/PUT.
  - `O_addr`/`O_data` hold their last values when no strobe is active.
- **Counter:** 8 bits, no carry out. Wrap-around after 255 terminates the transfer; the counter never rolls to 0 and continues.
- **Reset values (asynchronous):** state IDLE; all outputs 0; counter 0; page 0; parity 0; data latch 0.
- **Reset mid-transfer:** aborts immediately with no partial write completion. `O_halt` drops asynchronously.

## Timing
- All outputs are registered from state; no combinational path from inputs to outputs.
- HALT is entered the cycle after `I_start`.
- Total length after the halt cycle: 512 cycles if already aligned, 513 with ALIGN.
- Get and put cycles alternate strictly. Every GET falls on a parity-0 cycle.
- The last PUT's `O_write` falls in the final busy cycle. `O_halt`=0 on the next cycle.
- A new `I_start` is accepted in the cycle after returning to IDLE.

## Configuration
- **`OAM_DMA_DMC_STALL_EN` defined:** adds input `I_dmc_stall` (1 bit).
  - When `I_dmc_stall`=1 in a would-be GET cycle: no read, counter held, go to ALIGN, then retry GET on the next parity-0 cycle.
  - Each stall costs 2 cycles. PUT cycles are never stalled.
- **`OAM_DMA_DMC_STALL_EN` undefined:** the port is absent. Timing is exactly as in §Timing.

## Structure
- Package `oam_dma_pkg` holds:
  - the state enum `oam_dma_state_t` (IDLE, HALT, ALIGN, GET, PUT);
  - the constant `OAM_DMA_LAST = 8'hFF`;
  - the default OAM port constant.
- Single module with no sub-module. The parity flop, counter, page latch and data latch are all local.

## Test plan
- **Aligned start.** `I_page`=8'h02, `I_start` pulsed, `I_cpu_read`=1, next parity 0 → first read at 16'h0200 and first write to 16'h2004 carrying memory[16'h0200]. The last read is at 16'h02FF. `O_halt` lasts 513 cycles including the halt cycle.
- **Misaligned start.** Same as the aligned case but the next parity is 1 → exactly one ALIGN cycle with no strobes. `O_halt` lasts 514 cycles.
- **CPU write cycles delay the halt.** `I_cpu_read`=0 for 3 cycles after `I_start` → the engine stays in HALT with no strobes. The transfer starts after the first read cycle.
- **Data integrity and re-trigger.** Preload memory with incrementing bytes 8'h00..8'hFF at page 8'h07 → 256 writes with matching sequential data. An `I_start` mid-transfer is ignored.
- **Reset mid-transfer.** Assert `I_reset` after 100 puts → outputs drop to 0 immediately. A subsequent `I_start` runs a full 256-byte transfer.
- **Stall (macro defined).** `I_dmc_stall`=1 on the 10th GET → that byte is delayed 2 cycles and still written correctly. Total length grows by 2.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
// Shared definitions for the sprite DMA engine.
//   oam_dma_state_t : FSM state encoding (IDLE, HALT, ALIGN, GET, PUT)
//   OAM_DMA_LAST    : byte index of the final transfer beat
//   OAM_DMA_PORT    : default PPU OAM data port address
// -----------------------------------------------------------------------------
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    GET,
    PUT
  } oam_dma_state_t;

  localparam logic [7:0]  OAM_DMA_LAST = 8'hFF;
  localparam logic [15:0] OAM_DMA_PORT = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Sprite DMA engine. A one-cycle I_start (write to $4014) latches the page
// number, halts the CPU on its next read cycle and then copies 256 bytes from
// $XX00-$XXFF to the OAM data port using alternating get/put bus cycles.
// Get cycles always land on parity-0 cycles of a free-running parity flop.
//
// Ports:
//   I_clock     CPU cycle clock
//   I_reset     asynchronous, active-high reset
//   I_start     one-cycle start pulse (ignored unless idle)
//   I_page      page number, sampled with I_start
//   I_cpu_read  current CPU cycle is a read; the halt may only land on one
//   I_data      bus read data, captured at the end of a get cycle
//   I_dmc_stall (OAM_DMA_DMC_STALL_EN only) defers the upcoming get cycle
//   O_halt      RDY-low request / bus ownership
//   O_busy      transfer pending or active (equals O_halt)
//   O_addr      bus address; holds its last value between strobes
//   O_data      bus write data; doubles as the data latch
//   O_read      get-cycle strobe
//   O_write     put-cycle strobe
//
// Build option: define OAM_DMA_DMC_STALL_EN to add the I_dmc_stall input.
// All outputs are registered: each transition loads the strobes/address for
// the state being entered, so strobes line up with the state register.
// -----------------------------------------------------------------------------
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int          P_page_width = 8,
  parameter logic [15:0] P_oam_port   = OAM_DMA_PORT
) (
  input  logic                    I_clock,
  input  logic                    I_reset,
  input  logic                    I_start,
  input  logic [P_page_width-1:0] I_page,
  input  logic                    I_cpu_read,
  input  logic [7:0]              I_data,
`ifdef OAM_DMA_DMC_STALL_EN
  input  logic                    I_dmc_stall,
`endif
  output logic                    O_halt,
  output logic                    O_busy,
  output logic [15:0]             O_addr,
  output logic [7:0]              O_data,
  output logic                    O_read,
  output logic                    O_write
);

  oam_dma_state_t          state;
  logic                    parity;   // 0 = get cycle, 1 = put cycle
  logic [P_page_width-1:0] page;
  logic [7:0]              count;
  logic [7:0]              count_next;
  logic [P_page_width+7:0] get_addr;
  logic                    get_ok;
  logic                    go_get;

`ifdef OAM_DMA_DMC_STALL_EN
  // The strobe for a get cycle is registered, so the stall request is taken
  // in the cycle before the would-be get. A refused get becomes a dead
  // parity-0 cycle followed by a parity-1 align cycle: two cycles per stall.
  assign get_ok = ~I_dmc_stall;
`else
  assign get_ok = 1'b1;
`endif

  // Entering GET is only legal when the next cycle has parity 0.
  assign go_get = parity & get_ok;

  // The byte index advances on the put-to-get transition, so the address of
  // the upcoming get must use the incremented value.
  assign count_next = (state == PUT) ? count + 8'd1 : count;
  assign get_addr   = {page, count_next};

  assign O_busy = O_halt;

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would let later statements
  // see same-cycle values and break the registered-output timing.
  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state   <= IDLE;
      parity  <= 1'b0;
      page    <= '0;
      count   <= '0;
      O_halt  <= 1'b0;
      O_addr  <= '0;
      O_data  <= '0;
      O_read  <= 1'b0;
      O_write <= 1'b0;
    end else begin
      parity  <= ~parity;
      O_read  <= 1'b0;
      O_write <= 1'b0;

      case (state)
        IDLE: begin
          if (I_start) begin
            page   <= I_page;
            count  <= '0;
            state  <= HALT;
            O_halt <= 1'b1;
          end
        end

        // HALT waits for a CPU read cycle; ALIGN always proceeds once the
        // parity allows a get.
        HALT, ALIGN: begin
          if (state == ALIGN || I_cpu_read) begin
            if (go_get) begin
              state  <= GET;
              O_read <= 1'b1;
              O_addr <= 16'(get_addr);
            end else begin
              state <= ALIGN;
            end
          end
        end

        GET: begin
          state   <= PUT;
          O_data  <= I_data;
          O_addr  <= P_oam_port;
          O_write <= 1'b1;
        end

        PUT: begin
          if (count == OAM_DMA_LAST) begin
            state  <= IDLE;
            O_halt <= 1'b0;
          end else begin
            count <= count_next;
            if (go_get) begin
              state  <= GET;
              O_read <= 1'b1;
              O_addr <= 16'(get_addr);
            end else begin
              state <= ALIGN;
            end
          end
        end

        default: begin
          state  <= IDLE;
          O_halt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A table of transfer scenarios (page, CPU
// write cycles before the halt, alignment, optional mid-transfer restart and
// stall) is applied in a loop; reset-state, reset-abort and back-to-back start
// sequences are written out by hand. A background monitor records every bus
// strobe; expected bytes come from the bench's own memory-fill function.
// -----------------------------------------------------------------------------
module tb_oam_dma;
  import oam_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  page;
  logic        cpu_read;
  logic [7:0]  rdata;
  logic        halt, busy, rd, wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
`ifdef OAM_DMA_DMC_STALL_EN
  logic        dmc_stall;
`endif

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  assign rdata = mem[addr];

  oam_dma #(
    .P_page_width(8),
    .P_oam_port  (16'h2004)
  ) dut (
    .I_clock    (clk),
    .I_reset    (rst),
    .I_start    (start),
    .I_page     (page),
    .I_cpu_read (cpu_read),
    .I_data     (rdata),
`ifdef OAM_DMA_DMC_STALL_EN
    .I_dmc_stall(dmc_stall),
`endif
    .O_halt     (halt),
    .O_busy     (busy),
    .O_addr     (addr),
    .O_data     (wdata),
    .O_read     (rd),
    .O_write    (wr)
  );

  // Memory contents: page 7 holds 00..FF, every other page a scrambled pattern.
  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    if (a[15:8] == 8'h07) return a[7:0];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  // Reference parity: 0 after reset, toggles every cycle.
  logic mpar;
  always @(posedge clk or posedge rst) begin
    if (rst) mpar <= 1'b0;
    else     mpar <= ~mpar;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int          cyc = 0;
  int          halt_len, first_halt, last_halt, first_rd, last_wr;
  int          alt_err, par_err, busy_err, port_err;
  logic        prev_rd;
  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      if (busy !== halt) busy_err++;
      if (halt) begin
        if (halt_len == 0) first_halt = cyc;
        halt_len++;
        last_halt = cyc;
      end
      if (rd) begin
        if (rd_q.size() == 0) first_rd = cyc;
        rd_q.push_back(addr);
        if (mpar !== 1'b0) par_err++;
        if (prev_rd || wr) alt_err++;
      end
      if (wr) begin
        wr_q.push_back(wdata);
        last_wr = cyc;
        if (addr !== 16'h2004) port_err++;
        if (!prev_rd) alt_err++;
      end
      prev_rd = rd;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic clear_mon();
    halt_len = 0; first_halt = -1; last_halt = -1; first_rd = -1; last_wr = -2;
    alt_err = 0; par_err = 0; busy_err = 0; port_err = 0;
    prev_rd = 1'b0;
    rd_q.delete();
    wr_q.delete();
  endtask

  // Inputs are driven and outputs inspected 2 time units after the active
  // edge, after the monitor has logged the cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) until the engine releases the bus. Optional restart pulse
  // and stall request are driven along the way.
  task automatic wait_done(input int restart_at, input int stall_at, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (halt_len == 0 || halt) begin
      start = (restart_at > 0 && n == restart_at);
      if (start) page = 8'h33;
`ifdef OAM_DMA_DMC_STALL_EN
      dmc_stall = (stall_at > 0 && wr && wr_q.size() == stall_at - 1);
`endif
      tick();
      n++;
      if (n > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
`ifdef OAM_DMA_DMC_STALL_EN
    dmc_stall = 1'b0;
`endif
  endtask

  task automatic verify(input string tag, input logic [7:0] pg, input int exp_len,
                        input int exp_off, input logic [15:0] exp_first,
                        input logic [15:0] exp_last);
    int mism, amism;
    logic [15:0] a;
    mism = 0;
    amism = 0;
    check({tag, ".halt_len"}, halt_len, exp_len);
    check({tag, ".first_read_offset"}, first_rd - first_halt, exp_off);
    check({tag, ".reads"}, rd_q.size(), 256);
    check({tag, ".writes"}, wr_q.size(), 256);
    if (rd_q.size() > 0) begin
      check({tag, ".first_addr"}, rd_q[0], exp_first);
      check({tag, ".last_addr"}, rd_q[rd_q.size()-1], exp_last);
    end
    for (int i = 0; i < 256; i++) begin
      a = {pg, 8'(i)};
      if (i < wr_q.size() && wr_q[i] !== exp_byte(a)) mism++;
      if (i < rd_q.size() && rd_q[i] !== a) amism++;
    end
    check({tag, ".data_mismatches"}, mism, 0);
    check({tag, ".addr_mismatches"}, amism, 0);
    check({tag, ".last_write_in_last_busy"}, last_wr, last_halt);
    check({tag, ".get_put_alternation_errs"}, alt_err, 0);
    check({tag, ".get_parity_errs"}, par_err, 0);
    check({tag, ".busy_vs_halt_errs"}, busy_err, 0);
    check({tag, ".put_port_errs"}, port_err, 0);
    check({tag, ".idle_strobes"}, {rd, wr, halt}, 3'b000);
    check({tag, ".idle_addr_hold"}, addr, 16'h2004);
    check({tag, ".idle_data_hold"}, wdata, exp_byte({pg, 8'hFF}));
  endtask

  // Starts a transfer with the halt cycle placed on the requested parity.
  task automatic run_transfer(input logic [7:0] pg, input int pre, input bit aligned,
                              input int restart_at, input int stall_at,
                              output bit timed_out);
    bit need;
    // Halt cycle is S+1+pre; aligned means its parity is 1.
    need = aligned ^ bit'((pre + 1) % 2);
    while (mpar != need) tick();
    clear_mon();
    start = 1'b1;
    page  = pg;
    cpu_read = 1'b0;
    tick();
    start = 1'b0;
    page  = 8'hEE;
    for (int k = 0; k < pre; k++) begin
      cpu_read = 1'b0;
      tick();
      check("halt_wait_no_strobes", {rd, wr, halt}, 3'b001);
    end
    cpu_read = 1'b1;
    wait_done(restart_at, stall_at, timed_out);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  pg;
    int          pre;
    bit          aligned;
    int          restart_at;
    int          stall_at;
    int          exp_len;
    int          exp_off;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [$];

  initial begin
    bit   to;
    bit   s_par;
    int   n;

    rst = 1'b1; start = 1'b0; page = 8'h00; cpu_read = 1'b0;
`ifdef OAM_DMA_DMC_STALL_EN
    dmc_stall = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = exp_byte(16'(i));

    repeat (3) @(posedge clk);
    #2;
    check("reset_strobes", {halt, busy, rd, wr}, 4'b0000);
    check("reset_addr", addr, 16'h0000);
    check("reset_data", wdata, 8'h00);
    rst = 1'b0;
    tick();
    tick();
    check("idle_no_start", {halt, rd, wr}, 3'b000);

    //          name          pg     pre al rst  stl len  off first     last
    vecs.push_back('{"aligned",    8'h02, 0, 1, 0,   0,  513, 1, 16'h0200, 16'h02FF});
    vecs.push_back('{"misaligned", 8'h02, 0, 0, 0,   0,  514, 2, 16'h0200, 16'h02FF});
    vecs.push_back('{"cpu_wr_al",  8'h05, 3, 1, 0,   0,  516, 4, 16'h0500, 16'h05FF});
    vecs.push_back('{"cpu_wr_mis", 8'h05, 3, 0, 0,   0,  517, 5, 16'h0500, 16'h05FF});
    vecs.push_back('{"incr_retrig",8'h07, 0, 1, 200, 0,  513, 1, 16'h0700, 16'h07FF});
`ifdef OAM_DMA_DMC_STALL_EN
    vecs.push_back('{"stall",      8'h0A, 0, 1, 0,   10, 515, 1, 16'h0A00, 16'h0AFF});
`endif

    foreach (vecs[i]) begin
      run_transfer(vecs[i].pg, vecs[i].pre, vecs[i].aligned,
                   vecs[i].restart_at, vecs[i].stall_at, to);
      check({vecs[i].name, ".timeout"}, 32'(to), 0);
      verify(vecs[i].name, vecs[i].pg, vecs[i].exp_len, vecs[i].exp_off,
             vecs[i].exp_first, vecs[i].exp_last);
    end

    // Reset in the middle of a transfer, after 100 puts.
    clear_mon();
    start = 1'b1; page = 8'h03; cpu_read = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (wr_q.size() < 100 && n < 2000) begin
      tick();
      n++;
    end
    check("abort.reached_100_puts", wr_q.size(), 100);
    rst = 1'b1;
    #1;
    check("abort.strobes_drop", {halt, busy, rd, wr}, 4'b0000);
    check("abort.addr_zero", addr, 16'h0000);
    check("abort.data_zero", wdata, 8'h00);
    #2;
    rst = 1'b0;
    tick();
    tick();
    check("abort.stays_idle", {halt, rd, wr}, 3'b000);
    run_transfer(8'h04, 0, 1'b1, 0, 0, to);
    check("after_abort.timeout", 32'(to), 0);
    verify("after_abort", 8'h04, 513, 1, 16'h0400, 16'h04FF);

    // Start accepted in the first idle cycle after a transfer.
    clear_mon();
    s_par = mpar;
    start = 1'b1; page = 8'h11; cpu_read = 1'b1;
    tick();
    start = 1'b0;
    page = 8'hEE;
    check("b2b.halt_next_cycle", halt, 1'b1);
    wait_done(0, 0, to);
    check("b2b.timeout", 32'(to), 0);
    verify("b2b", 8'h11, (s_par == 1'b0) ? 513 : 514, (s_par == 1'b0) ? 1 : 2,
           16'h1100, 16'h11FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
